multicycle_seq: RTL and testbench

- Multi-cycle sequencer for the WISC-SP13 datapath (fetch, decode/register file, ALU, data memory, writeback).
- Replaces the single-cycle implicit timing with an explicit FSM.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Gates the register-file write enable, PC update, IR load and memory requests.
- Handles memory ready handshakes, halt and a stall watchdog.

---
 rtl/multicycle_seq.sv | 84 ++++++++
 tb/tb_multicycle_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_seq.sv
// multicycle_seq: FETCH/DECODE/EXEC/MEM/WB sequencer for the WISC-SP13 datapath
module multicycle_seq #(
    parameter logic [7:0] TIMEOUT = 8'd64,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ctl_regwrite,
    input  logic             ctl_memread,
    input  logic             ctl_memwrite,
    input  logic             ctl_halt,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_wr,
    output logic             ir_write,
    output logic             rf_write,
    output logic             pc_write,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERR} state_t;
    state_t     cur, nxt;
    logic [7:0] wcnt;
    logic       waiting, expired;
    assign waiting = (cur == FETCH && !imem_ready) || (cur == MEM && !dmem_ready);
    assign expired = waiting && TIMEOUT != 8'd0 && wcnt == TIMEOUT;
    assign state   = cur;
    assign halted  = cur == HALTED;
    assign err     = cur == ERR;
    // state, wait counter and retire counter; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur         <= IDLE;
            wcnt        <= 8'd0;
            instr_count <= '0;
        end else begin
            cur         <= nxt;
            wcnt        <= waiting ? wcnt + 8'd1 : 8'd0;
            instr_count <= instr_count + CNT_W'(pc_write);
        end
    end
    // next state and Mealy enables for the current step of the instruction
    always_comb begin
        nxt      = cur;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_wr  = 1'b0;
        ir_write = 1'b0;
        rf_write = 1'b0;
        pc_write = 1'b0;
        case (cur)
            IDLE:   nxt = start ? FETCH : IDLE;
            FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                nxt      = imem_ready ? DECODE : expired ? ERR : FETCH;
            end
            DECODE: nxt = ctl_halt ? HALTED : EXEC;
            EXEC: begin
                pc_write = !ctl_memread && !ctl_memwrite && !ctl_regwrite;
                nxt      = (ctl_memread && ctl_memwrite) ? ERR :
                           (ctl_memread || ctl_memwrite) ? MEM :
                           ctl_regwrite ? WB : FETCH;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_wr  = ctl_memwrite;
                pc_write = dmem_ready && !ctl_memread;
                nxt      = dmem_ready ? (ctl_memread ? WB : FETCH) : expired ? ERR : MEM;
            end
            WB: begin
                rf_write = 1'b1;
                pc_write = 1'b1;
                nxt      = FETCH;
            end
            default: nxt = cur;
        endcase
    end
endmodule

// File: tb/tb_multicycle_seq.sv
// tb_multicycle_seq: trace-model checker for the multi-cycle sequencer
module tb_multicycle_seq;
    localparam int TO = 4;
    localparam int K_ALU0 = 0, K_ALU1 = 1, K_LD = 2, K_ST = 3, K_HLT = 4, K_BAD = 5;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic ctl_regwrite = 1'b0, ctl_memread = 1'b0, ctl_memwrite = 1'b0, ctl_halt = 1'b0;
    logic imem_ready = 1'b0, dmem_ready = 1'b0;
    logic imem_req, dmem_req, dmem_wr, ir_write, rf_write, pc_write, halted, err;
    logic [2:0] state;
    logic [3:0] instr_count;

    multicycle_seq #(.TIMEOUT(8'd4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ctl_regwrite(ctl_regwrite), .ctl_memread(ctl_memread),
        .ctl_memwrite(ctl_memwrite), .ctl_halt(ctl_halt),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_wr(dmem_wr),
        .ir_write(ir_write), .rf_write(rf_write), .pc_write(pc_write),
        .halted(halted), .err(err), .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // one cycle of the expected trace: inputs to apply and outputs required
    typedef struct {
        logic       start, rw, mr, mw, hl, ir, dr;
        logic [2:0] st;
        logic [5:0] o;
        logic [3:0] cnt;
    } step_t;

    step_t stim_q[$];
    step_t exp_q[$];
    int    checks = 0, errors = 0;
    int    m_cnt = 0;
    int    n_ir = 0, n_rf = 0, n_pc = 0, n_ireq = 0, n_dreq = 0;
    logic  c_rw, c_mr, c_mw, c_hl;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // o = {imem_req, dmem_req, dmem_wr, ir_write, rf_write, pc_write}
    task automatic put(input logic [2:0] st, input logic [5:0] o, input logic ir,
                       input logic dr, input logic st_in, input bit ctl_ok);
        step_t s;
        s.start = st_in;
        s.rw = ctl_ok ? c_rw : rb();
        s.mr = ctl_ok ? c_mr : rb();
        s.mw = ctl_ok ? c_mw : rb();
        s.hl = ctl_ok ? c_hl : rb();
        s.ir = ir;
        s.dr = dr;
        s.st = st;
        s.o = o;
        s.cnt = 4'(m_cnt);
        stim_q.push_back(s);
        if (o[0]) m_cnt = (m_cnt + 1) % 16;
    endtask

    task automatic term(input int st, input int n);
        for (int i = 0; i < n; i++) put(3'(st), 6'b0, rb(), rb(), rb(), 1'b0);
    endtask

    task automatic idle(input logic s);
        put(3'd0, 6'b0, rb(), rb(), s, 1'b0);
    endtask

    // expected trace of one instruction; fin = terminal state reached (0 if none)
    task automatic instr(input int k, input int iw, input int dw, output int fin);
        fin = 0;
        c_rw = (k == K_ALU1) || (k == K_LD);
        c_mr = (k == K_LD) || (k == K_BAD);
        c_mw = (k == K_ST) || (k == K_BAD);
        c_hl = (k == K_HLT);
        for (int i = 0; i < iw; i++) begin
            put(3'd1, 6'b100000, 1'b0, rb(), 1'b0, 1'b0);
            if (i == TO) begin fin = 7; return; end
        end
        put(3'd1, 6'b100100, 1'b1, rb(), 1'b0, 1'b0);
        put(3'd2, 6'b0, rb(), rb(), 1'b0, 1'b1);
        if (c_hl) begin fin = 6; return; end
        if (k == K_BAD) begin put(3'd3, 6'b0, rb(), rb(), 1'b0, 1'b1); fin = 7; return; end
        if (k == K_LD || k == K_ST) begin
            put(3'd3, 6'b0, rb(), rb(), 1'b0, 1'b1);
            for (int i = 0; i < dw; i++) begin
                put(3'd4, {2'b01, c_mw, 3'b000}, rb(), 1'b0, 1'b0, 1'b1);
                if (i == TO) begin fin = 7; return; end
            end
            put(3'd4, {2'b01, c_mw, 2'b00, c_mw}, rb(), 1'b1, 1'b0, 1'b1);
            if (k == K_LD) put(3'd5, 6'b000011, rb(), rb(), 1'b0, 1'b1);
        end else if (k == K_ALU1) begin
            put(3'd3, 6'b0, rb(), rb(), 1'b0, 1'b1);
            put(3'd5, 6'b000011, rb(), rb(), 1'b0, 1'b1);
        end else begin
            put(3'd3, 6'b000001, rb(), rb(), 1'b0, 1'b1);
        end
    endtask

    task automatic run(input int k, input int iw, input int dw, input int n_term);
        int f;
        instr(k, iw, dw, f);
        if (f != 0) term(f, n_term);
    endtask

    task automatic play();
        step_t s;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(posedge clk);
            #1;
            start = s.start; ctl_regwrite = s.rw; ctl_memread = s.mr;
            ctl_memwrite = s.mw; ctl_halt = s.hl; imem_ready = s.ir; dmem_ready = s.dr;
            exp_q.push_back(s);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_cnt = 0;
        n_ir = 0; n_rf = 0; n_pc = 0; n_ireq = 0; n_dreq = 0;
    endtask

    // compare DUT against the expected trace on every modelled cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            step_t e;
            logic [14:0] act, want;
            e = exp_q.pop_front();
            act  = {state, imem_req, dmem_req, dmem_wr, ir_write, rf_write, pc_write, halted, err, instr_count};
            want = {e.st, e.o, e.st == 3'd6, e.st == 3'd7, e.cnt};
            checks++;
            if (act !== want) begin
                errors++;
                $display("FAIL trace t=%0t: got st=%0d o=%b h=%b e=%b cnt=%0d want st=%0d o=%b h=%b e=%b cnt=%0d",
                         $time, act[14:12], act[11:6], act[5], act[4], act[3:0],
                         want[14:12], want[11:6], want[5], want[4], want[3:0]);
            end
            n_ir += int'(ir_write); n_rf += int'(rf_write); n_pc += int'(pc_write);
            n_ireq += int'(imem_req); n_dreq += int'(dmem_req);
        end
    end

    initial begin
        #12;
        chk("reset_outputs", int'({state, imem_req, dmem_req, dmem_wr, ir_write, rf_write, pc_write, halted, err, instr_count}), 0);
        do_reset();

        idle(1'b0); idle(1'b1);
        run(K_ALU1, 0, 0, 0);
        run(K_LD, 0, 3, 0);
        run(K_ST, 1, 2, 0);
        run(K_HLT, 0, 0, 4);
        play();
        chk("s1_count", int'(instr_count), 3);
        chk("s1_halted", int'(halted), 1);
        chk("s1_rf_pulses", n_rf, 2);
        chk("s1_pc_pulses", n_pc, 3);
        chk("s1_ir_pulses", n_ir, 4);
        chk("s1_dmem_cycles", n_dreq, 7);

        do_reset();
        idle(1'b1);
        run(K_ALU1, 4, 0, 0);
        run(K_ALU0, 9, 0, 3);
        play();
        chk("s2_err", int'(err), 1);
        chk("s2_state", int'(state), 7);
        chk("s2_imem_cycles", n_ireq, 10);
        chk("s2_ir_pulses", n_ir, 1);
        chk("s2_count", int'(instr_count), 1);

        do_reset();
        idle(1'b1);
        run(K_ALU0, 0, 0, 0);
        run(K_BAD, 0, 0, 3);
        play();
        chk("s3_err", int'(err), 1);
        chk("s3_count", int'(instr_count), 1);
        chk("s3_dmem_cycles", n_dreq, 0);

        do_reset();
        idle(1'b1);
        run(K_ST, 0, 4, 0);
        run(K_LD, 0, 7, 3);
        play();
        chk("s4_err", int'(err), 1);
        chk("s4_count", int'(instr_count), 1);
        chk("s4_rf_pulses", n_rf, 0);
        chk("s4_dmem_cycles", n_dreq, 10);

        do_reset();
        idle(1'b1);
        for (int i = 0; i < 17; i++) run(K_ALU0, 0, 0, 0);
        run(K_HLT, 0, 0, 2);
        play();
        chk("s5_count_wrap", int'(instr_count), 1);
        chk("s5_pc_pulses", n_pc, 17);

        do_reset();
        idle(1'b1);
        run(K_ALU0, 0, 0, 0);
        run(K_LD, 0, 10, 0);
        while (stim_q.size() > 8) void'(stim_q.pop_back());
        play();
        chk("s6_in_mem", int'(state), 4);
        chk("s6_dmem_req", int'(dmem_req), 1);
        chk("s6_count_before", int'(instr_count), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("s6_async_state", int'(state), 0);
        chk("s6_async_outputs", int'({imem_req, dmem_req, dmem_wr, ir_write, rf_write, pc_write, halted, err}), 0);
        chk("s6_async_count", int'(instr_count), 0);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
